// File: rtl/syndrome_calc_pkg.sv
// Shared definitions for the streaming BCH syndrome calculator over GF(2^10).
// Holds the field constants, the code-select encoding and the constant-power
// GF helpers that the Horner cells and the even-syndrome squaring use.
package syndrome_calc_pkg;

    localparam int M = 10;

    // x^10 reduces to x^3 + 1 under the primitive polynomial x^10 + x^3 + 1.
    localparam logic [M-1:0] PRIM_POLY = 10'h009;

    localparam int N_63   = 63;
    localparam int N_255  = 255;
    localparam int N_1023 = 1023;

    typedef enum logic [1:0] {
        CODE_63   = 2'b00,
        CODE_255  = 2'b01,
        CODE_1023 = 2'b10
    } code_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    // The reserved select value falls back to the longest code.
    function automatic code_t decode_code(input logic [1:0] sel);
        case (sel)
            2'b00:   return CODE_63;
            2'b01:   return CODE_255;
            default: return CODE_1023;
        endcase
    endfunction

    function automatic int beats_for(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

    // value * alpha^power. Always called with a constant power, so the loop
    // unrolls into a fixed XOR matrix rather than a general multiplier.
    function automatic logic [M-1:0] gf_mul_const(input logic [M-1:0] value, input int power);
        logic [M-1:0] v;
        v = value;
        for (int i = 0; i < power; i++)
            v = {v[M-2:0], 1'b0} ^ (v[M-1] ? PRIM_POLY : '0);
        return v;
    endfunction

    // Squaring is linear in characteristic 2: bit i maps to alpha^(2i).
    function automatic logic [M-1:0] gf_square(input logic [M-1:0] value);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            if (value[i]) r ^= gf_mul_const(M'(1), 2 * i);
        return r;
    endfunction

endpackage

// File: rtl/syndrome_calc_if.sv
// Beat input and syndrome output bundle of syndrome_calc.
//   i_code  : code select, sampled on a word's first beat
//   i_valid : beat qualifier (no backpressure)
//   i_data  : P-bit beat, MSB carries the highest polynomial degree
//   o_S1..o_S8 : published syndromes, held until the next word completes
//   o_zero  : all syndromes zero;  o_valid : one-cycle publish pulse
interface syndrome_calc_if
    import syndrome_calc_pkg::*;
#(
    parameter int P = 8
) ();
    logic [1:0]   i_code;
    logic         i_valid;
    logic [P-1:0] i_data;
    logic [M-1:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
    logic         o_zero;
    logic         o_valid;

    modport slave (
        input  i_code, i_valid, i_data,
        output o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8, o_zero, o_valid
    );

    modport master (
        output i_code, i_valid, i_data,
        input  o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8, o_zero, o_valid
    );
endinterface

// File: rtl/syndrome_calc_cell.sv
// One Horner accumulator for syndrome S_J.
//   clk, rst : clock and synchronous active-high reset
//   load     : first beat of a word, accumulator term replaced by zero
//   en       : beat qualifier, accumulator updates only when high
//   beat     : P-bit beat (already padding-masked)
//   next     : accumulator value including the current beat
module syndrome_calc_cell
    import syndrome_calc_pkg::*;
#(
    parameter int P = 8,
    parameter int J = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [P-1:0] beat,
    output logic [M-1:0] next
);
    logic [M-1:0] acc;
    logic [M-1:0] beat_term;

    always_comb begin
        beat_term = '0;
        for (int k = 0; k < P; k++)
            if (beat[k]) beat_term ^= gf_mul_const(M'(1), J * k);
    end

    assign next = (load ? '0 : gf_mul_const(acc, J * P)) ^ beat_term;

    always_ff @(posedge clk) begin
        if (rst)     acc <= '0;
        else if (en) acc <= next;
    end
endmodule

// File: rtl/syndrome_calc.sv
// Streaming BCH syndrome calculator, GF(2^10), P bits per beat.
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus          : syndrome_calc_if slave (beats in, S1..S8 / zero / valid out)
// Odd syndromes come from Horner cells; even ones are squares taken when the
// output registers load, so the output path never disturbs the accumulators.
//
// state   | meaning
// ST_IDLE | waiting for the first beat of a word
// ST_ACC  | mid-word, counting beats toward the latched code's beat count
module syndrome_calc
    import syndrome_calc_pkg::*;
#(
    parameter int P = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    syndrome_calc_if.slave  bus
);
    localparam int MAX_BEATS = beats_for(N_1023, P);
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] BEATS_63   = CNT_W'(beats_for(N_63, P));
    localparam logic [CNT_W-1:0] BEATS_255  = CNT_W'(beats_for(N_255, P));
    localparam logic [CNT_W-1:0] BEATS_1023 = CNT_W'(beats_for(N_1023, P));

    // Padding sits in the MSBs of the first beat.
    localparam logic [P-1:0] MASK_63   = {P{1'b1}} >> (beats_for(N_63, P) * P - N_63);
    localparam logic [P-1:0] MASK_255  = {P{1'b1}} >> (beats_for(N_255, P) * P - N_255);
    localparam logic [P-1:0] MASK_1023 = {P{1'b1}} >> (beats_for(N_1023, P) * P - N_1023);

    state_t           state;
    code_t            code_q;
    code_t            code_eff;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] beats_eff;
    logic [P-1:0]     pad_mask;
    logic [P-1:0]     beat;
    logic             first_beat;
    logic             final_beat;
    logic [M-1:0]     nxt [4];
    logic [M-1:0]     s1, s2, s3, s4, s5, s6, s7, s8;
    logic             zero_q, valid_q;

    assign first_beat = bus.i_valid && (state == ST_IDLE);
    assign code_eff   = first_beat ? decode_code(bus.i_code) : code_q;

    always_comb begin
        beats_eff = BEATS_1023;
        pad_mask  = MASK_1023;
        case (code_eff)
            CODE_63:  begin beats_eff = BEATS_63;  pad_mask = MASK_63;  end
            CODE_255: begin beats_eff = BEATS_255; pad_mask = MASK_255; end
            default:  begin beats_eff = BEATS_1023; pad_mask = MASK_1023; end
        endcase
    end

    assign cnt_next   = first_beat ? CNT_W'(1) : cnt + CNT_W'(1);
    assign final_beat = bus.i_valid && (cnt_next == beats_eff);
    assign beat       = first_beat ? (bus.i_data & pad_mask) : bus.i_data;

    for (genvar g = 0; g < 4; g++) begin : g_cell
        syndrome_calc_cell #(.P(P), .J(2 * g + 1)) u_cell (
            .clk  (i_clk),
            .rst  (i_rst),
            .load (first_beat),
            .en   (bus.i_valid),
            .beat (beat),
            .next (nxt[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            code_q  <= CODE_63;
            cnt     <= '0;
            s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
            s5 <= '0; s6 <= '0; s7 <= '0; s8 <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.i_valid) begin
                if (first_beat) code_q <= code_eff;
                if (final_beat) begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    s1 <= nxt[0];
                    s2 <= gf_square(nxt[0]);
                    s3 <= nxt[1];
                    s4 <= gf_square(gf_square(nxt[0]));
                    s5 <= nxt[2];
                    s6 <= gf_square(nxt[1]);
                    s7 <= nxt[3];
                    s8 <= gf_square(gf_square(gf_square(nxt[0])));
                    // Even syndromes are squares of odd ones, so the odds decide.
                    zero_q  <= ~|{nxt[0], nxt[1], nxt[2], nxt[3]};
                    valid_q <= 1'b1;
                end else begin
                    state <= ST_ACC;
                    cnt   <= cnt_next;
                end
            end
        end
    end

    assign bus.o_S1    = s1;
    assign bus.o_S2    = s2;
    assign bus.o_S3    = s3;
    assign bus.o_S4    = s4;
    assign bus.o_S5    = s5;
    assign bus.o_S6    = s6;
    assign bus.o_S7    = s7;
    assign bus.o_S8    = s8;
    assign bus.o_zero  = zero_q;
    assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_syndrome_calc.sv
module tb_syndrome_calc;
    localparam int P = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    syndrome_calc_if #(.P(P)) bus ();

    syndrome_calc #(.P(P)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0]      cyc;
        logic             zero;
        logic [7:0][9:0]  s;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            cur;
    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic            rst_seen = 1'b1;
    logic [9:0]      exp_tab [1023];
    logic [P-1:0]    beat_q[$];
    logic [7:0][9:0] held     = '0;
    logic            held_zero = 1'b0;
    logic [7:0][9:0] outv;

    assign outv = {bus.o_S8, bus.o_S7, bus.o_S6, bus.o_S5,
                   bus.o_S4, bus.o_S3, bus.o_S2, bus.o_S1};

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Multiply by x modulo x^10 + x^3 + 1.
    function automatic logic [9:0] mulx(input logic [9:0] v);
        return {v[8:0], 1'b0} ^ (v[9] ? 10'h009 : 10'h000);
    endfunction

    function automatic int code_n(input logic [1:0] code);
        return (code == 2'b00) ? 63 : (code == 2'b01) ? 255 : 1023;
    endfunction

    // Direct evaluation S_j = sum over set bits r_d of alpha^(d*j).
    task automatic model(input int n, output logic [7:0][9:0] s);
        int nb;
        int d;
        nb = (n + P - 1) / P;
        s = '0;
        for (int t = 0; t < nb; t++)
            for (int b = 0; b < P; b++) begin
                d = (nb - 1 - t) * P + b;
                if (d < n && beat_q[t][b])
                    for (int j = 1; j <= 8; j++)
                        s[j-1] ^= exp_tab[(d * j) % 1023];
            end
    endtask

    task automatic fill_random(input logic [1:0] code);
        int nb;
        nb = (code_n(code) + P - 1) / P;
        beat_q = {};
        for (int t = 0; t < nb; t++) beat_q.push_back(P'($urandom));
    endtask

    task automatic fill_single(input logic [1:0] code, input int d);
        int nb;
        nb = (code_n(code) + P - 1) / P;
        beat_q = {};
        for (int t = 0; t < nb; t++) beat_q.push_back('0);
        beat_q[nb - 1 - d / P][d % P] = 1'b1;
    endtask

    task automatic run_word(input logic [1:0] code, input int gap_pct, input bit toggle,
                            input bit ovr, input logic [7:0][9:0] ovr_s);
        logic [7:0][9:0] s;
        exp_t x;
        int nb;
        int gaps;
        nb = (code_n(code) + P - 1) / P;
        model(code_n(code), s);
        if (ovr) s = ovr_s;
        for (int t = 0; t < nb; t++) begin
            gaps = 0;
            while (gap_pct > 0 && gaps < 3 && $urandom_range(99) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_data  = P'($urandom);
                bus.i_code  = 2'($urandom);
                gaps++;
                @(posedge clk); #1;
            end
            bus.i_valid = 1'b1;
            bus.i_data  = beat_q[t];
            bus.i_code  = (t == 0 || !toggle) ? code : 2'($urandom);
            if (t == nb - 1) begin
                x.cyc  = 32'(cyc + 1);
                x.s    = s;
                x.zero = (s == '0);
                exp_q.push_back(x);
            end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            chk("reset_outputs", {78'(outv), bus.o_zero, bus.o_valid}, 80'h0);
            held      = '0;
            held_zero = 1'b0;
        end else if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 80'(bus.o_valid), 80'h0);
            end else begin
                cur = exp_q.pop_front();
                chk("latency", 80'(cyc), 80'(cur.cyc));
                for (int j = 0; j < 8; j++)
                    chk($sformatf("S%0d", j + 1), 80'(outv[j]), 80'(cur.s[j]));
                chk("zero", 80'(bus.o_zero), 80'(cur.zero));
                held      = cur.s;
                held_zero = cur.zero;
            end
        end else begin
            chk("held", {79'(outv), bus.o_zero}, {79'(held), held_zero});
        end
    end

    initial begin
        logic [7:0][9:0] cs;
        exp_tab[0] = 10'h001;
        for (int e = 1; e < 1023; e++) exp_tab[e] = mulx(exp_tab[e-1]);

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_code  = 2'b00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // all-zero word, N=63
        fill_single(2'b00, 0);
        beat_q[7] = '0;
        run_word(2'b00, 0, 1'b0, 1'b1, '0);

        // single 1 at position 0, N=255: every S_j = 1
        fill_single(2'b01, 0);
        for (int j = 0; j < 8; j++) cs[j] = 10'h001;
        run_word(2'b01, 0, 1'b0, 1'b1, cs);

        // single 1 at position 1: S_j = alpha^j
        fill_single(2'b01, 1);
        cs = {10'h100, 10'h080, 10'h040, 10'h020, 10'h010, 10'h008, 10'h004, 10'h002};
        run_word(2'b01, 0, 1'b0, 1'b1, cs);

        // single 1 at position 10: S1 = 0x009, rest from the model
        fill_single(2'b01, 10);
        model(255, cs);
        cs[0] = 10'h009;
        run_word(2'b01, 0, 1'b0, 1'b1, cs);

        // random words across codes, including the reserved select value
        for (int w = 0; w < 6; w++) begin
            logic [1:0] c;
            c = 2'(w % 4);
            fill_random(c);
            run_word(c, (w % 2) * 25, 1'b0, 1'b0, '0);
        end

        // back-to-back N=1023 words, gaps only in the second
        fill_random(2'b10);
        run_word(2'b10, 0, 1'b0, 1'b0, '0);
        fill_random(2'b10);
        run_word(2'b10, 30, 1'b0, 1'b0, '0);

        // reset at beat 20 of a 32-beat word, then a fresh word
        fill_random(2'b01);
        for (int t = 0; t < 20; t++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = beat_q[t];
            bus.i_code  = 2'b01;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.i_data = beat_q[20];
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        fill_random(2'b01);
        run_word(2'b01, 0, 1'b0, 1'b0, '0);

        // code toggled mid-word and padding bit forced high
        fill_random(2'b00);
        beat_q[0][P-1] = 1'b1;
        run_word(2'b00, 20, 1'b1, 1'b0, '0);
        fill_random(2'b01);
        beat_q[0][P-1] = 1'b1;
        run_word(2'b01, 0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("pending_words", 80'(exp_q.size()), 80'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/syndrome_calc.md
# syndrome_calc

Streaming BCH syndrome calculator over GF(2^10) that sits directly upstream of the syndrome switch. It consumes one received (hard-decision, test-pattern-applied) codeword as P-bit beats and produces the eight syndromes S1..S8 with a one-cycle valid pulse. One instance runs per test-pattern lane (tp1..tp4), feeding the switch's i_tpN_S* and valid inputs.

## Interface
- P, 8, bits per input beat
- M, 10, field width (fixed to 10; parameter for readability only)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_code  in  2  code select: 2'b00 → N=63, 2'b01 → N=255, 2'b10 → N=1023; 2'b11 reserved, treated as 2'b10
- i_valid  in  1  beat qualifier; no backpressure
- i_data  in  P  beat; i_data[P-1] highest polynomial degree
- o_S1..o_S8  out  10 each  syndromes S_j = r(α^j), held until next word completes
- o_zero  out  1  all eight syndromes zero (valid with o_valid, held with outputs)
- o_valid  out  1  one-cycle pulse: o_S*/o_zero updated

## Operation
- Field: primitive polynomial x^10 + x^3 + 1; α = 10'h002.
- Word = ceil(N/P) beats (P=8: 8 / 32 / 128 beats). First transmitted bit is r_{N-1}. The first beat is zero-padded in its MSBs (P·beats − N bits, 1 bit for P=8). Padding bits are masked to 0 regardless of input value.
- Horner per beat: S_j ← S_j·α^(jP) ⊕ Σ_k i_data[k]·α^(jk). On the first beat of a word, the accumulator term is replaced by 0 (load, not accumulate).
- i_code is sampled on the first beat of each word and latched. Changes mid-word are ignored.
- States:
  - IDLE: waiting for a beat. i_valid → ACC, beat counter = 1, latch code.
  - ACC: each i_valid beat increments the counter. When a beat lands on the final count:
    - accumulator results (including that beat) are copied into the output registers;
    - o_valid is asserted next cycle;
    - state → IDLE.
  - Gaps (i_valid=0) are allowed anywhere; state and accumulators are held.
- Back-to-back words: a first beat in the cycle after a final beat starts the new word cleanly. Output registers are separate from the accumulators, so published syndromes are not disturbed.
- Even syndromes must equal squares of lower ones (S2=S1², S4=S2², S6=S3², S8=S4²). Computing only the odd syndromes and squaring them is permitted.
- Reset: state IDLE, counter 0, accumulators 0, o_S1..o_S8 = 0, o_zero = 0, o_valid = 0. Reset mid-word discards the partial word and produces no o_valid.

## Timing
- Latency: final beat at cycle t → o_valid=1 and new o_S*/o_zero at cycle t+1 (registered outputs).
- o_valid is high for exactly one cycle per completed word; it never asserts for partial words.
- Minimum word spacing is beats-per-word cycles; full-rate streaming is supported with no dead cycle.
- Critical path: one constant-matrix GF multiply plus a P-input XOR tree per syndrome; no GF general multiplier.

## Structure
- Shared package holds:
  - M;
  - primitive polynomial constant 10'h009 (reduction of x^10);
  - code-length and beat-count constants per i_code;
  - a function gf_mul_const(value, power) returning value·α^power (matrix built at elaboration);
  - the square function for even syndromes.
- Sub-module syndrome_calc_cell (parameter J): one Horner accumulator for S_J, with ports for load/enable/beat. Instantiated for J=1,3,5,7; even syndromes derived by squaring at output-register load.

## Test plan
- All-zero word, code 2'b00 (8 beats) → o_valid at final beat + 1, all S = 10'h000, o_zero=1.
- Single 1 at position 0 (last beat, i_data[0]=1), code 2'b01 → all S_j = 10'h001, o_zero=0.
- Single 1 at position 1 → S1..S8 = 10'h002, 004, 008, 010, 020, 040, 080, 100. Single 1 at position 10 → S1 = 10'h009.
- Two words back-to-back, code 2'b10 (128 beats each), with random i_valid gaps in the second → two o_valid pulses, each matching the software model. The first word's outputs stay held until the second completes.
- i_rst asserted at beat 20 of 32, then a fresh word → no o_valid for the aborted word; correct syndromes for the fresh one.
- i_code toggled mid-word, plus a 1 driven in the padding bit → ignored: beat count and syndromes follow the code latched at the first beat.
